prog_ctr_fsm: RTL

Program-counter stage that sits directly downstream of the branch-target lookup table. Holds the 10-bit instruction address, advances it by one each cycle, loads the table's absolute target on a taken branch, and sequences program start, stall and halt through a three-state controller. Its `prog_ctr` output drives instruction-memory addressing; `done` signals program completion to the testbench/top level.

---
 rtl/prog_ctr_fsm.sv | 117 +++++++++++
 1 files changed

// File: rtl/prog_ctr_fsm.sv
// Program-counter stage with an IDLE/RUN/DONE controller.
// Holds the instruction address and advances it by one each RUN cycle.
// A taken branch loads the lookup table's absolute target instead.
// Start, stall and halt are sequenced by a three-state FSM.
// Optional feature macro: PC_CYCLE_COUNT_EN adds a saturating RUN-cycle
// counter and the cycle_count output port.
module prog_ctr_fsm #(
  parameter int D  = 10,
  parameter int CW = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [D-1:0] start_addr,
  input  logic         branch,
  input  logic [D-1:0] target,
  input  logic         stall,
  input  logic         halt,
  output logic [D-1:0] prog_ctr,
  output logic         running,
  output logic         done
`ifdef PC_CYCLE_COUNT_EN
  ,
  output logic [CW-1:0] cycle_count
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t       state_q, state_d;
  logic [D-1:0] prog_ctr_q, prog_ctr_d;

  // Sequential increment wraps modulo 2^D with no carry out.
  function automatic logic [D-1:0] pc_inc(input logic [D-1:0] pc);
    return pc + {{(D-1){1'b0}}, 1'b1};
  endfunction

  // State and program-counter registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prog_ctr_q <= '0;
    end else begin
      state_q    <= state_d;
      prog_ctr_q <= prog_ctr_d;
    end
  end

  // Next-state and next-PC selection: halt > stall > branch > increment.
  always_comb begin
    state_d    = state_q;
    prog_ctr_d = prog_ctr_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d    = S_RUN;
          prog_ctr_d = start_addr;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_d = S_DONE;
        end else if (stall) begin
          prog_ctr_d = prog_ctr_q;
        end else if (branch) begin
          prog_ctr_d = target;
        end else begin
          prog_ctr_d = pc_inc(prog_ctr_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign prog_ctr = prog_ctr_q;
  assign running  = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

`ifdef PC_CYCLE_COUNT_EN
  logic [CW-1:0] cycle_count_q, cycle_count_d;

  // Saturating increment: sticks at the all-ones value.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  // Cycle-counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else begin
      cycle_count_q <= cycle_count_d;
    end
  end

  // Count every RUN cycle (stalls and the halt cycle included); clear on start.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (state_q == S_RUN) begin
      cycle_count_d = sat_inc(cycle_count_q);
    end else if (start) begin
      cycle_count_d = '0;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  localparam int cw_unused = CW;
`endif

endmodule
